// File: rtl/sb_xform_pkg.sv
// Shared constants and the per-byte operation
// encoding for the byte transform stream block.
package sb_xform_pkg;

  localparam int DEST_W = 32;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_SUB  = 2'd3
  } mode_e;

endpackage

// File: rtl/sb_xform_fifo.sv
// Synchronous FIFO of DEPTH words of W bits.
// Ports: push/wdata in, pop/rdata out, full/empty status.
module sb_xform_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Pointers are exactly AW bits wide, so
  // they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/sb_byte_xform.sv
// Per-byte pass/add/xor/sub stream transform with FIFO.
// Ports: in_* / out_* valid-ready beats, mode, operand, done, pkt_count.
module sb_byte_xform
  import sb_xform_pkg::*;
#(
  parameter int DW    = 256,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [1:0]        mode,
  input  logic [7:0]        operand,
  input  logic [DW-1:0]     in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [31:0]       pkt_count
);

  localparam int NB = DW / 8;
  localparam int FW = DW + DEST_W + 1;

  logic          accept;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW-1:0] xdata;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;

  function automatic logic [7:0] xbyte(
    input logic [7:0] b,
    input mode_e      m,
    input logic [7:0] op
  );
    logic [7:0] r;
    r = b;
    unique case (m)
      MODE_PASS: r = b;
      MODE_ADD:  r = b + op;
      MODE_XOR:  r = b ^ op;
      MODE_SUB:  r = b - op;
      default:   r = b;
    endcase
    return r;
  endfunction

  // Each byte is computed in its own 8-bit lane,
  // so carries and borrows stay inside the byte.
  always_comb begin
    xdata = '0;
    for (int i = 0; i < NB; i++) begin
      xdata[i*8 +: 8] = xbyte(in_data[i*8 +: 8],
                              mode_e'(mode), operand);
    end
  end

  assign in_ready  = nreset && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign wdata     = {xdata, in_dest, in_last};

  sb_xform_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (accept),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Payload is zeroed whenever nothing valid is
  // presented, which also covers reset.
  always_comb begin
    out_data = '0;
    out_dest = '0;
    out_last = 1'b0;
    if (nreset && out_valid) begin
      {out_data, out_dest, out_last} = rdata;
    end
  end

  // Terminate detection looks at the raw beat,
  // before the transform is applied.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      done      <= 1'b0;
      pkt_count <= '0;
    end else if (accept) begin
      if (&in_data) done <= 1'b1;
      if (in_last)  pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sb_byte_xform.sv
// Directed self-checking bench for sb_byte_xform.
// Inputs change and outputs are checked on the falling edge.
module tb_sb_byte_xform;

  localparam int DW    = 256;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic [1:0]    mode;
  logic [7:0]    operand;
  logic [DW-1:0] in_data;
  logic [31:0]   in_dest;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_dest;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic [31:0]   pkt_count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  sb_byte_xform #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .mode     (mode),
    .operand  (operand),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_dest (out_dest),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done),
    .pkt_count(pkt_count)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  initial begin
    nreset    = 1'b0;
    mode      = 2'd0;
    operand   = 8'h00;
    in_data   = '0;
    in_dest   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    step();
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_dest", DW'(out_dest), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_pkt", DW'(pkt_count), '0);
    nreset = 1'b1;
    #1;
    chk("rel_in_ready", DW'(in_ready), DW'(1));

    // add 0x01 to all-0x10
    @(negedge clk);
    mode = 2'd1; operand = 8'h01;
    in_data = fill(8'h10); in_dest = 32'hABCD0001;
    in_last = 1'b1; in_valid = 1'b1;
    #1;
    chk("no_bypass", DW'(out_valid), '0);
    step();
    in_valid = 1'b0;
    chk("add_valid", DW'(out_valid), DW'(1));
    chk("add_data", out_data, fill(8'h11));
    chk("add_dest", DW'(out_dest), DW'(32'hABCD0001));
    chk("add_last", DW'(out_last), DW'(1));
    chk("add_pkt", DW'(pkt_count), DW'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("add_drained", DW'(out_valid), '0);

    // add wrap: 0xFF -> 0x00, neighbours unaffected
    in_data = fill(8'h10);
    in_data[15:8] = 8'hFF;
    in_data[7:0]  = 8'h7F;
    in_last = 1'b0; in_dest = 32'h5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_d = fill(8'h11);
    exp_d[15:8] = 8'h00;
    exp_d[7:0]  = 8'h80;
    chk("add_wrap", out_data, exp_d);
    chk("add_wrap_last", DW'(out_last), '0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // sub 0x02 from 0x01 -> 0xFF
    mode = 2'd3; operand = 8'h02;
    in_data = fill(8'h01); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sub_wrap", out_data, fill(8'hFF));
    chk("sub_no_done", DW'(done), '0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // xor and pass
    mode = 2'd2; operand = 8'h5A;
    in_data = fill(8'hA5); in_valid = 1'b1;
    step();
    mode = 2'd0; operand = 8'h77;
    in_data = fill(8'h3C);
    step();
    in_valid = 1'b0;
    chk("xor_data", out_data, fill(8'hFF));
    out_ready = 1'b1;
    step();
    chk("pass_data", out_data, fill(8'h3C));
    step();
    out_ready = 1'b0;
    chk("pass_drained", DW'(out_valid), '0);

    // backpressure: 5 offered, 4 accepted
    mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_data = fill(8'h20 + 8'(i));
      in_valid = 1'b1;
      chk("bp_ready", DW'(in_ready), DW'(1));
      step();
    end
    in_data = fill(8'h24);
    chk("bp_full", DW'(in_ready), '0);
    step();
    chk("bp_still_full", DW'(in_ready), '0);
    chk("bp_head", out_data, fill(8'h20));
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) chk("bp_pop_full", DW'(in_ready), '0);
      chk("bp_valid", DW'(out_valid), DW'(1));
      chk("bp_order", out_data, fill(8'h20 + 8'(j)));
      step();
      if (j == 1) in_valid = 1'b0;
    end
    chk("bp_empty", DW'(out_valid), '0);
    out_ready = 1'b0;

    // steady push+pop at occupancy 2
    in_valid = 1'b1;
    in_data = fill(8'h40); step();
    in_data = fill(8'h41); step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = fill(8'h42 + 8'(k));
      chk("pp_ready", DW'(in_ready), DW'(1));
      chk("pp_order", out_data, fill(8'h40 + 8'(k)));
      step();
    end
    in_valid = 1'b0;
    chk("pp_rem0", out_data, fill(8'h4A));
    step();
    chk("pp_rem1", out_data, fill(8'h4B));
    step();
    chk("pp_occ2", DW'(out_valid), '0);
    out_ready = 1'b0;

    // terminate: all-ones, xor 0xFF
    mode = 2'd2; operand = 8'hFF;
    in_data = '1; in_last = 1'b1; in_valid = 1'b1;
    #1;
    chk("term_pre", DW'(done), '0);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("term_done", DW'(done), DW'(1));
    chk("term_data", out_data, '0);
    chk("term_fwd", DW'(out_valid), DW'(1));
    chk("term_pkt", DW'(pkt_count), DW'(2));
    out_ready = 1'b1;
    mode = 2'd0;
    in_data = fill(8'h01); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("term_hold", DW'(done), DW'(1));
    out_ready = 1'b0;

    // reset with 3 beats buffered
    in_last = 1'b1; in_valid = 1'b1;
    for (int m = 0; m < 3; m++) begin
      in_data = fill(8'h60 + 8'(m));
      step();
    end
    in_valid = 1'b0;
    chk("mid_pkt", DW'(pkt_count), DW'(5));
    nreset = 1'b0;
    step();
    chk("mid_valid", DW'(out_valid), '0);
    chk("mid_pkt0", DW'(pkt_count), '0);
    chk("mid_done0", DW'(done), '0);
    chk("mid_data0", out_data, '0);
    chk("mid_ready0", DW'(in_ready), '0);
    nreset = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("mid_no_stale", DW'(out_valid), '0);
    end
    in_data = fill(8'h70); in_last = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("mid_new", out_data, fill(8'h70));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_byte_xform.md
SB_BYTE_XFORM -- requirements
Module: sb_byte_xform

Interface
REQ-001 SHALL have parameter DW, default 256, meaning data width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries; legal values are powers of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port nreset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port mode, input, 2 bits: 0 pass, 1 add, 2 xor, 3 sub.
REQ-006 SHALL have port operand, input, 8 bits: per-byte operand.
REQ-007 SHALL have ports in_data (input, DW), in_dest (input, 32) and in_last (input, 1): the receive beat.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): receive handshake.
REQ-009 SHALL have ports out_data (output, DW), out_dest (output, 32) and out_last (output, 1): the transmit beat.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): transmit handshake.
REQ-011 SHALL have port done, output, 1 bit: sticky terminate flag.
REQ-012 SHALL have port pkt_count, output, 32 bits: count of accepted beats with last=1.

Function
REQ-013 SHALL accept an input beat on any rising edge where in_valid && in_ready.
REQ-014 SHALL transform the data on accept, per byte i, using mode/operand sampled that cycle:
- pass: byte unchanged.
- add: byte + operand, mod 256.
- xor: byte ^ operand.
- sub: byte - operand, mod 256.
REQ-015 SHALL keep carries from crossing byte boundaries.
REQ-016 SHALL pass in_dest and in_last through unmodified with their beat.
REQ-017 SHALL store accepted beats in a FIFO of DEPTH entries and present the head on out_*.
REQ-018 SHALL have a latency of 1 cycle: a beat accepted at edge N into an empty FIFO shows out_valid=1 after edge N.
REQ-019 SHALL never combinationally bypass from input to output.
REQ-020 SHALL drive in_ready = (occupancy < DEPTH), independent of out_ready; when full, in_ready stays 0 even in a cycle with a pop.
REQ-021 SHALL pop the head on a rising edge where out_valid && out_ready.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL leave occupancy unchanged on a simultaneous push and pop.
REQ-024 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-025 SHALL set done, from the cycle after accept, when an accepted pre-transform in_data is all ones; done stays set until reset.
REQ-026 SHALL still forward that all-ones beat normally.
REQ-027 SHALL increment pkt_count on each accepted beat with in_last=1, wrapping 0xFFFFFFFF to 0.
REQ-028 SHALL allow mode/operand changes between beats without affecting beats already buffered.

Reset
REQ-029 SHALL, with nreset=0 at a rising edge, clear occupancy and pointers, out_valid, done and pkt_count.
REQ-030 SHALL drive out_data, out_dest and out_last to 0 during reset.
REQ-031 SHALL drive in_ready to 0 while nreset=0, and to 1 on the first cycle after release.
REQ-032 SHALL discard buffered beats on a reset mid-operation, with no output after release until new accepts.

Structure
REQ-033 SHALL take the mode enumeration (PASS/ADD/XOR/SUB) and the DEST_W=32 constant from shared package sb_xform_pkg.
REQ-034 SHALL implement buffering in sub-module sb_xform_fifo, parameterised by width (DW+32+1) and DEPTH; the per-byte transform stays in sb_byte_xform.

Verification
REQ-035 SHALL cover add: mode=1, operand=0x01, in_data all 0x10 -> out_data all 0x11 one cycle later; dest and last unchanged.
REQ-036 SHALL cover wrap arithmetic: mode=1, operand=0x01, byte 0xFF -> 0x00 with neighbours unchanged; mode=3, operand=0x02, byte 0x01 -> 0xFF.
REQ-037 SHALL cover backpressure with DEPTH=4, out_ready=0 and 5 offered beats:
- 4 accepted, then in_ready=0.
- Raising out_ready drains them in order, then the 5th is accepted.
REQ-038 SHALL cover simultaneous push and pop at occupancy 2 for 10 cycles -> occupancy stays 2 and order is preserved.
REQ-039 SHALL cover terminate: all-ones beat with mode=2, operand=0xFF -> out_data all 0x00 and done=1 next cycle; done holds after further beats.
REQ-040 SHALL cover reset mid-operation: 3 beats buffered, nreset=0 one cycle -> out_valid=0, pkt_count=0, done=0, no stale beats emitted.
